llatch_bank_wr_ctrl: RTL and testbench
======================================

// Module: llatch_bank_wr_ctrl
// PURPOSE
//  Write sequencer/arbiter for a bank of LUT-feedback level-sensitive latches (llatch family).
//  Round-robin arbitrates NREQ write requesters and drives shared data plus a one-hot gate per word.
//  Each write runs as a SETUP/GATE/HOLD sequence, so D is stable around every gate pulse.
//  Sits between the requesting logic and the latch bank, which is instantiated outside this block.
// PARAMETERS
//  NREQ      2  number of requesters (>=1)
//  DEPTH     8  latch words in bank (>=2); AW = $clog2(DEPTH)
//  WIDTH     8  bits per word
//  SETUP_CYC 1  cycles D is driven before the gate opens (>=1)
//  GATE_CYC  1  cycles the gate is held high (>=1)
//  HOLD_CYC  1  cycles D is held after the gate closes (>=1)
// PORTS
//  C      in  1           clock, rising edge
//  R      in  1           reset, synchronous, active-high
//  req    in  NREQ        write request per requester, level
//  addr   in  NREQ*AW     word address; requester i uses slice [i*AW +: AW]
//  wdata  in  NREQ*WIDTH  write data; requester i uses slice [i*WIDTH +: WIDTH]
//  gnt    out NREQ        one-hot, 1-cycle completion ack
//  err    out 1           1-cycle pulse with gnt when addr >= DEPTH
//  lat_d  out WIDTH       shared D to all latch words
//  lat_g  out DEPTH       one-hot gate (G) per word; all-zero outside GATE
//  busy   out 1           high in every state except IDLE
// BEHAVIOUR
//  - All outputs are registered. While R is high: state=IDLE, rr_ptr=0, gnt=0, err=0, lat_d=0, lat_g=0, busy=0.
//  - FSM states IDLE, SETUP, GATE, HOLD, ACK. Transitions:
//      IDLE->SETUP   when any req is high.
//      SETUP->GATE   after SETUP_CYC cycles.
//      GATE->HOLD    after GATE_CYC cycles.
//      HOLD->ACK     after HOLD_CYC cycles.
//      ACK->IDLE     always, after 1 cycle.
//  - Phase counter: $clog2(max cycle param + 1) bits. Cleared on every state entry.
//  - Arbitration (IDLE only): round-robin starting at rr_ptr.
//      Winner w's addr/wdata are captured in the IDLE->SETUP edge; later input changes are ignored.
//      lat_d <= wdata[w] on that same edge.
//  - rr_ptr <= (w+1) mod NREQ on the ACK->IDLE edge.
//  - GATE: lat_g[addr_w] = 1. If addr_w >= DEPTH, lat_g stays 0.
//  - lat_d holds its value through SETUP, GATE, HOLD and ACK; it changes only on the next capture.
//  - ACK: gnt[w] = 1 for exactly one cycle; err = 1 in that cycle if addr_w >= DEPTH.
//  - Latency: req sampled at edge k -> gnt high in the cycle after edge k+SETUP_CYC+GATE_CYC+HOLD_CYC+1.
//  - Throughput: one write per SETUP_CYC+GATE_CYC+HOLD_CYC+2 cycles (IDLE always lasts >=1 cycle).
//  - Requester protocol: drop req in the gnt cycle. A req still high in IDLE is a new write.
//  - A req dropped before gnt does not abort a write already in progress.
//  - R asserted mid-write: lat_g=0 at the next edge, write abandoned, no gnt.
//      The target word may hold partial data.
//  - Simultaneous reqs: only the winner is served; losers wait, with no starvation (at most NREQ-1 writes ahead).
// CONFIGURATION
//  LLATCH_WR_CTRL_CLR_EN defined:
//  - Adds input clr (1 bit, level). In IDLE, clr takes priority over every req.
//  - Clear sequence: lat_d=0, then SETUP/GATE/HOLD with lat_g all-ones (every word).
//  - Then ACK with gnt=0 and err=0; rr_ptr is unchanged.
//  - Output clr_done pulses 1 cycle in ACK.
//  LLATCH_WR_CTRL_CLR_EN undefined: no clr/clr_done ports, and lat_g is never more than one-hot.
// TESTING
//  - Single write, defaults: req[0]=1, addr=3, wdata=8'hA5 at edge 0 ->
//      lat_d=A5 from edge 1; lat_g=8'h08 only in the cycle after edge 2; gnt=2'b01 in the cycle after edge 4.
//  - Contention: req=2'b11 held after reset -> gnt order 01,10,01,10; each gnt 5 cycles apart;
//      lat_g never has more than one bit set.
//  - Out of range, DEPTH=6: addr=7 -> lat_g=0 throughout; gnt and err pulse together.
//  - Timing params SETUP=2, GATE=3, HOLD=1 -> lat_g high exactly 3 cycles;
//      lat_d stable from 2 cycles before gate rise to 1 cycle after gate fall; gnt 7 cycles after sample.
//  - Reset mid-GATE: R=1 for 1 cycle -> lat_g=0, busy=0, no gnt; the next req is served by requester 0.
//  - With LLATCH_WR_CTRL_CLR_EN: clr=1 and req[1]=1 together -> lat_g=8'hFF with lat_d=0 and clr_done first;
//      then req[1] is served.

Source files
------------

// File: rtl/llatch_bank_wr_ctrl.sv
// llatch_bank_wr_ctrl: round-robin write sequencer driving shared D and one-hot gates of a latch bank.
// Optional whole-bank clear sequence is enabled by defining LLATCH_WR_CTRL_CLR_EN.
module llatch_bank_wr_ctrl #(
   parameter int unsigned NREQ      = 2,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned SETUP_CYC = 1,
   parameter int unsigned GATE_CYC  = 1,
   parameter int unsigned HOLD_CYC  = 1
) (
   input  logic                               C,
   input  logic                               R,
   input  logic [NREQ-1:0]                    req,
   input  logic [NREQ*$clog2(DEPTH)-1:0]      addr,
   input  logic [NREQ*WIDTH-1:0]              wdata,
   output logic [NREQ-1:0]                    gnt,
   output logic                               err,
   output logic [WIDTH-1:0]                   lat_d,
   output logic [DEPTH-1:0]                   lat_g,
   output logic                               busy
`ifdef LLATCH_WR_CTRL_CLR_EN
   ,
   input  logic                               clr,
   output logic                               clr_done
`endif
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned WW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned MAXC = (SETUP_CYC > GATE_CYC) ?
                                  ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                                  ((GATE_CYC > HOLD_CYC) ? GATE_CYC : HOLD_CYC);
   localparam int unsigned CW   = $clog2(MAXC + 1);

   typedef enum logic [2:0] {IDLE, SETUP, GATE, HOLD, ACK} state_t;

   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [WW-1:0]     rr_ptr, rr_ptr_n;
   logic [WW-1:0]     win, win_n;
   logic [AW-1:0]     addr_q, addr_n;
   logic              clr_q, clr_n;
   logic [NREQ-1:0]   gnt_n;
   logic              err_n;
   logic [WIDTH-1:0]  lat_d_n;
   logic [DEPTH-1:0]  lat_g_n;
   logic              busy_n;
   logic              clr_req_c;
   logic              found_c;
   logic [WW-1:0]     pick_c;
   logic [WW-1:0]     idx_c;
   logic              oor_c;
   logic [DEPTH-1:0]  gate_vec_c;
`ifdef LLATCH_WR_CTRL_CLR_EN
   logic              clr_done_n;
   assign clr_req_c = clr;
`else
   assign clr_req_c = 1'b0;
`endif

   // Round-robin pick: first active request at or after rr_ptr.
   always_comb begin
      found_c = 1'b0;
      pick_c  = rr_ptr;
      idx_c   = rr_ptr;
      for (int i = 0; i < int'(NREQ); i++) begin
         idx_c = WW'((int'(rr_ptr) + i) % int'(NREQ));
         if (!found_c && req[idx_c]) begin
            found_c = 1'b1;
            pick_c  = idx_c;
         end
      end
   end

   // Widened compare so the out-of-range test also works when DEPTH is a power of two.
   assign oor_c      = {1'b0, addr_q} >= (AW+1)'(DEPTH);
   assign gate_vec_c = clr_q ? {DEPTH{1'b1}} :
                       (oor_c ? {DEPTH{1'b0}} : (DEPTH'(1) << addr_q));

   // Next-state and next-output logic; outputs are registered from the next state.
   always_comb begin
      state_n  = state;
      cnt_n    = CW'(cnt + 1'b1);
      rr_ptr_n = rr_ptr;
      win_n    = win;
      addr_n   = addr_q;
      clr_n    = clr_q;
      lat_d_n  = lat_d;
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (clr_req_c) begin
               state_n = SETUP;
               clr_n   = 1'b1;
               lat_d_n = '0;
            end else if (found_c) begin
               state_n = SETUP;
               clr_n   = 1'b0;
               win_n   = pick_c;
               addr_n  = addr[int'(pick_c)*AW +: AW];
               lat_d_n = wdata[int'(pick_c)*WIDTH +: WIDTH];
            end
         end
         SETUP: begin
            if (cnt == CW'(SETUP_CYC - 1)) begin
               state_n = GATE;
               cnt_n   = '0;
            end
         end
         GATE: begin
            if (cnt == CW'(GATE_CYC - 1)) begin
               state_n = HOLD;
               cnt_n   = '0;
            end
         end
         HOLD: begin
            if (cnt == CW'(HOLD_CYC - 1)) begin
               state_n = ACK;
               cnt_n   = '0;
            end
         end
         ACK: begin
            state_n = IDLE;
            cnt_n   = '0;
            if (!clr_q) begin
               rr_ptr_n = (win == WW'(NREQ - 1)) ? '0 : WW'(win + 1'b1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase

      busy_n  = (state_n != IDLE);
      lat_g_n = (state_n == GATE) ? gate_vec_c : '0;
      gnt_n   = '0;
      err_n   = 1'b0;
      if (state_n == ACK && !clr_q) begin
         gnt_n[win] = 1'b1;
         err_n      = oor_c;
      end
`ifdef LLATCH_WR_CTRL_CLR_EN
      clr_done_n = (state_n == ACK) && clr_q;
`endif
   end

   // State, capture and output registers with synchronous reset.
   always_ff @(posedge C) begin
      if (R) begin
         state  <= IDLE;
         cnt    <= '0;
         rr_ptr <= '0;
         win    <= '0;
         addr_q <= '0;
         clr_q  <= 1'b0;
         gnt    <= '0;
         err    <= 1'b0;
         lat_d  <= '0;
         lat_g  <= '0;
         busy   <= 1'b0;
`ifdef LLATCH_WR_CTRL_CLR_EN
         clr_done <= 1'b0;
`endif
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         rr_ptr <= rr_ptr_n;
         win    <= win_n;
         addr_q <= addr_n;
         clr_q  <= clr_n;
         gnt    <= gnt_n;
         err    <= err_n;
         lat_d  <= lat_d_n;
         lat_g  <= lat_g_n;
         busy   <= busy_n;
`ifdef LLATCH_WR_CTRL_CLR_EN
         clr_done <= clr_done_n;
`endif
      end
   end

endmodule

// File: tb/tb_llatch_bank_wr_ctrl.sv
// tb_llatch_bank_wr_ctrl: directed checks of the latch-bank write sequencer in three configurations.
// Clear-sequence checks are compiled in when LLATCH_WR_CTRL_CLR_EN is defined.
`timescale 1ns/1ps
module tb_llatch_bank_wr_ctrl;

   logic C = 1'b0;
   logic R;
   always #5 C = ~C;

   int n_tests = 0;
   int n_fail  = 0;

   // a: defaults, b: DEPTH=6, c: SETUP=2 GATE=3 HOLD=1
   logic [1:0]  req_a, req_b, req_c;
   logic [5:0]  addr_a, addr_b, addr_c;
   logic [15:0] wdata_a, wdata_b, wdata_c;
   logic [1:0]  gnt_a, gnt_b, gnt_c;
   logic        err_a, err_b, err_c;
   logic [7:0]  lat_d_a, lat_d_b, lat_d_c;
   logic [7:0]  lat_g_a, lat_g_c;
   logic [5:0]  lat_g_b;
   logic        busy_a, busy_b, busy_c;
`ifdef LLATCH_WR_CTRL_CLR_EN
   logic        clr_a, clr_b, clr_c;
   logic        clr_done_a, clr_done_b, clr_done_c;
`endif

   llatch_bank_wr_ctrl u_a (
      .C(C), .R(R), .req(req_a), .addr(addr_a), .wdata(wdata_a),
      .gnt(gnt_a), .err(err_a), .lat_d(lat_d_a), .lat_g(lat_g_a), .busy(busy_a)
`ifdef LLATCH_WR_CTRL_CLR_EN
      , .clr(clr_a), .clr_done(clr_done_a)
`endif
   );

   llatch_bank_wr_ctrl #(.DEPTH(6)) u_b (
      .C(C), .R(R), .req(req_b), .addr(addr_b), .wdata(wdata_b),
      .gnt(gnt_b), .err(err_b), .lat_d(lat_d_b), .lat_g(lat_g_b), .busy(busy_b)
`ifdef LLATCH_WR_CTRL_CLR_EN
      , .clr(clr_b), .clr_done(clr_done_b)
`endif
   );

   llatch_bank_wr_ctrl #(.SETUP_CYC(2), .GATE_CYC(3), .HOLD_CYC(1)) u_c (
      .C(C), .R(R), .req(req_c), .addr(addr_c), .wdata(wdata_c),
      .gnt(gnt_c), .err(err_c), .lat_d(lat_d_c), .lat_g(lat_g_c), .busy(busy_c)
`ifdef LLATCH_WR_CTRL_CLR_EN
      , .clr(clr_c), .clr_done(clr_done_c)
`endif
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic do_reset();
      R       = 1'b1;
      req_a   = '0; req_b   = '0; req_c   = '0;
      addr_a  = '0; addr_b  = '0; addr_c  = '0;
      wdata_a = '0; wdata_b = '0; wdata_c = '0;
`ifdef LLATCH_WR_CTRL_CLR_EN
      clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
`endif
      tick();
      tick();
      R = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      int ge[4];
      int gv[4];
      int multi;
      logic [7:0] g_or;
      int gcount, rise, gbad, dbad, gnt_e;

      // Reset values
      do_reset();
      R = 1'b1;
      tick();
      check("rst_gnt",   32'(gnt_a),   32'h0);
      check("rst_err",   32'(err_a),   32'h0);
      check("rst_lat_d", 32'(lat_d_a), 32'h0);
      check("rst_lat_g", 32'(lat_g_a), 32'h0);
      check("rst_busy",  32'(busy_a),  32'h0);
      R = 1'b0;

      // Single write: requester 0, addr 3, data A5; later input changes must be ignored
      req_a = 2'b01; addr_a = 6'd3; wdata_a = 16'h00A5;
      tick();
      check("sw_lat_d_e1", 32'(lat_d_a), 32'hA5);
      check("sw_busy_e1",  32'(busy_a),  32'h1);
      check("sw_lat_g_e1", 32'(lat_g_a), 32'h0);
      addr_a = 6'd5; wdata_a = 16'h005A;
      tick();
      check("sw_lat_g_e2", 32'(lat_g_a), 32'h08);
      check("sw_lat_d_e2", 32'(lat_d_a), 32'hA5);
      tick();
      check("sw_lat_g_e3", 32'(lat_g_a), 32'h0);
      check("sw_gnt_e3",   32'(gnt_a),   32'h0);
      tick();
      check("sw_gnt_e4",   32'(gnt_a),   32'h1);
      check("sw_err_e4",   32'(err_a),   32'h0);
      check("sw_lat_d_e4", 32'(lat_d_a), 32'hA5);
      req_a = 2'b00;
      tick();
      check("sw_gnt_e5",  32'(gnt_a),  32'h0);
      check("sw_busy_e5", 32'(busy_a), 32'h0);

      // Contention: both requesters held high after reset
      do_reset();
      req_a = 2'b11; addr_a = {3'd5, 3'd2}; wdata_a = 16'h2211;
      k = 0; multi = 0;
      for (int i = 0; i < 4; i++) begin ge[i] = 0; gv[i] = 0; end
      for (int e = 1; e <= 20; e++) begin
         tick();
         if ($countones(lat_g_a) > 1) multi++;
         if (gnt_a != 2'b00) begin
            if (k < 4) begin ge[k] = e; gv[k] = int'(gnt_a); end
            k++;
         end
      end
      req_a = 2'b00;
      check("ct_gnt_count", 32'(k), 32'd4);
      check("ct_onehot",    32'(multi), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ct_gnt_val%0d", i),  32'(gv[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
         check($sformatf("ct_gnt_edge%0d", i), 32'(ge[i]), 32'(4 + 5 * i));
      end

      // Out of range with DEPTH=6: addr 7 never gates, err pulses with gnt
      do_reset();
      req_b = 2'b01; addr_b = 6'd7; wdata_b = 16'h003C;
      g_or = '0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         g_or = g_or | 8'(lat_g_b);
         if (e == 4) begin
            check("oor_gnt_e4", 32'(gnt_b), 32'h1);
            check("oor_err_e4", 32'(err_b), 32'h1);
            req_b = 2'b00;
         end
         if (e == 5) check("oor_err_e5", 32'(err_b), 32'h0);
      end
      check("oor_lat_g", 32'(g_or),    32'h0);
      check("oor_lat_d", 32'(lat_d_b), 32'h3C);

      // Timing SETUP=2 GATE=3 HOLD=1
      do_reset();
      req_c = 2'b01; addr_c = 6'd1; wdata_c = 16'h0077;
      gcount = 0; rise = 0; gbad = 0; dbad = 0; gnt_e = 0;
      for (int e = 1; e <= 9; e++) begin
         tick();
         if (lat_g_c != 8'h00) begin
            gcount++;
            if (rise == 0) rise = e;
            if (lat_g_c != 8'h02) gbad++;
         end
         if (e <= 7 && lat_d_c != 8'h77) dbad++;
         if (gnt_c == 2'b01) begin
            gnt_e = e;
            req_c = 2'b00;
         end
      end
      check("tm_gate_len",  32'(gcount), 32'd3);
      check("tm_gate_rise", 32'(rise),   32'd3);
      check("tm_gate_val",  32'(gbad),   32'd0);
      check("tm_lat_d",     32'(dbad),   32'd0);
      check("tm_gnt_edge",  32'(gnt_e),  32'd7);

      // Reset mid-GATE restarts round-robin at requester 0
      do_reset();
      req_a = 2'b01; addr_a = {3'd5, 3'd2}; wdata_a = 16'h4433;
      tick(); tick(); tick(); tick();
      check("rm_pre_gnt", 32'(gnt_a), 32'h1);
      req_a = 2'b00;
      tick();
      req_a = 2'b11;
      tick();
      tick();
      check("rm_gate_w1", 32'(lat_g_a), 32'h20);
      R = 1'b1;
      tick();
      check("rm_lat_g", 32'(lat_g_a), 32'h0);
      check("rm_busy",  32'(busy_a),  32'h0);
      check("rm_gnt",   32'(gnt_a),   32'h0);
      R = 1'b0;
      tick();
      tick();
      check("rm_gate_w0", 32'(lat_g_a), 32'h04);
      tick();
      tick();
      check("rm_gnt_w0", 32'(gnt_a), 32'h1);
      req_a = 2'b00;
      tick();

`ifdef LLATCH_WR_CTRL_CLR_EN
      // Clear takes priority over a pending request, then the request is served
      do_reset();
      clr_a = 1'b1; req_a = 2'b10; addr_a = {3'd6, 3'd0}; wdata_a = 16'h9900;
      tick();
      check("cl_lat_d", 32'(lat_d_a), 32'h0);
      clr_a = 1'b0;
      tick();
      check("cl_lat_g", 32'(lat_g_a), 32'hFF);
      tick();
      tick();
      check("cl_done", 32'(clr_done_a), 32'h1);
      check("cl_gnt",  32'(gnt_a),      32'h0);
      check("cl_err",  32'(err_a),      32'h0);
      tick();
      tick();
      check("cl_w1_lat_d", 32'(lat_d_a), 32'h99);
      tick();
      check("cl_w1_lat_g", 32'(lat_g_a), 32'h40);
      tick();
      tick();
      check("cl_w1_gnt", 32'(gnt_a), 32'h2);
      req_a = 2'b00;
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
